// File: rtl/vga_fb_sram_responder.sv
`timescale 1ns/1ps
// Framebuffer store answering VGA single-word reads after a fixed latency and
// accepting byte-masked CPU writes, with VGA reads taking priority.
module vga_fb_sram_responder #(
    parameter int unsigned DEPTH        = 384,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        read,
    input  logic [31:0] SRAM_address,
    input  logic [3:0]  byte_select_in,
    input  logic        cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byte_sel,
    output logic [31:0] data_from_SRAM,
    output logic        data_en,
    output logic [3:0]  byte_select_out,
    output logic        SRAM_busy,
    output logic        cpu_ack,
    output logic        addr_err
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 9;
    localparam int unsigned BW = 4;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP, WR_ACK} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_idx;
    logic [BW-1:0]   rd_sel;
    logic [DW-1:0]   mem [DEPTH];

    logic [AW-1:0]   cpu_idx_c;
    logic            cpu_in_range_c;
    logic            rd_in_range_c;
    logic            wr_fire_c;
    logic [DW-1:0]   lane_mask_c;
    logic [DW-1:0]   rd_word_c;
    logic            unused_addr_bits_c;

    // Only the low nine address bits select a word.
    assign unused_addr_bits_c = ^{SRAM_address[31:AW], cpu_address[31:AW]};

    assign cpu_idx_c      = cpu_address[AW-1:0];
    assign cpu_in_range_c = 32'(cpu_idx_c) < DEPTH;
    assign rd_in_range_c  = 32'(rd_idx) < DEPTH;
    assign wr_fire_c      = nrst && (state == IDLE) && !read && cpu_write && cpu_in_range_c;
    assign rd_word_c      = mem[rd_idx];

    always_comb begin
        lane_mask_c = '0;
        for (int b = 0; b < int'(BW); b++) begin
            lane_mask_c[8*b +: 8] = {8{rd_sel[b]}};
        end
    end

    // Store is deliberately outside the reset domain so contents survive nrst.
    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            for (int b = 0; b < int'(BW); b++) begin
                if (cpu_byte_sel[b]) begin
                    mem[cpu_idx_c][8*b +: 8] <= cpu_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= IDLE;
            count           <= '0;
            rd_idx          <= '0;
            rd_sel          <= '0;
            data_from_SRAM  <= '0;
            data_en         <= 1'b0;
            byte_select_out <= '0;
            SRAM_busy       <= 1'b0;
            cpu_ack         <= 1'b0;
            addr_err        <= 1'b0;
        end else begin
            data_en  <= 1'b0;
            cpu_ack  <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (read) begin
                        rd_idx    <= SRAM_address[AW-1:0];
                        rd_sel    <= byte_select_in;
                        count     <= CW'(READ_LATENCY - 1);
                        state     <= RD_WAIT;
                        SRAM_busy <= 1'b1;
                    end else if (cpu_write) begin
                        cpu_ack   <= 1'b1;
                        addr_err  <= !cpu_in_range_c;
                        state     <= WR_ACK;
                        SRAM_busy <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else begin
                        data_from_SRAM  <= rd_in_range_c ? (rd_word_c & lane_mask_c) : '0;
                        byte_select_out <= rd_sel;
                        data_en         <= 1'b1;
                        addr_err        <= !rd_in_range_c;
                        state           <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    state     <= IDLE;
                    SRAM_busy <= 1'b0;
                end
                WR_ACK: begin
                    state     <= IDLE;
                    SRAM_busy <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    SRAM_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fb_sram_responder.sv
`timescale 1ns/1ps
// Directed bench: stimulus pushes expected responses into queues, a negedge
// monitor pops and compares them whenever data_en or cpu_ack appears.
module tb_vga_fb_sram_responder;

    localparam int unsigned L     = 2;
    localparam int unsigned DEPTH = 384;

    logic        clk;
    logic        nrst;
    logic        read;
    logic [31:0] SRAM_address;
    logic [3:0]  byte_select_in;
    logic        cpu_write;
    logic [31:0] cpu_address;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byte_sel;
    logic [31:0] data_from_SRAM;
    logic        data_en;
    logic [3:0]  byte_select_out;
    logic        SRAM_busy;
    logic        cpu_ack;
    logic        addr_err;

    vga_fb_sram_responder #(.DEPTH(DEPTH), .READ_LATENCY(L)) dut (
        .clk(clk), .nrst(nrst), .read(read), .SRAM_address(SRAM_address),
        .byte_select_in(byte_select_in), .cpu_write(cpu_write),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
        .cpu_byte_sel(cpu_byte_sel), .data_from_SRAM(data_from_SRAM),
        .data_en(data_en), .byte_select_out(byte_select_out),
        .SRAM_busy(SRAM_busy), .cpu_ack(cpu_ack), .addr_err(addr_err)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  bsel;
        logic        aerr;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic        wr_q[$];
    logic [31:0] model [512];
    int          total;
    int          passed;
    logic        prev_den;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    function automatic rd_exp_t exp_read(input logic [8:0] idx, input logic [3:0] sel);
        rd_exp_t e;
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
        e.bsel = sel;
        if (32'(idx) >= DEPTH) begin
            e.data = '0;
            e.aerr = 1'b1;
        end else begin
            e.data = model[idx] & m;
            e.aerr = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!nrst) begin
            prev_den = 1'b0;
        end else begin
            if (data_en) begin
                check("den_not_back_to_back", 32'(prev_den), 32'd0);
                if (rd_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_data_en: data 0x%08h with no read outstanding", data_from_SRAM);
                end else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    check("rd_data", data_from_SRAM, e.data);
                    check("rd_bsel", 32'(byte_select_out), 32'(e.bsel));
                    check("rd_addr_err", 32'(addr_err), 32'(e.aerr));
                end
            end
            if (cpu_ack) begin
                check("ack_not_with_den", 32'(data_en), 32'd0);
                if (wr_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_cpu_ack: ack with no write outstanding");
                end else begin
                    logic ea;
                    ea = wr_q.pop_front();
                    check("wr_addr_err", 32'(addr_err), 32'(ea));
                end
            end
            prev_den = data_en;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (!SRAM_busy) break;
            @(posedge clk); #1;
        end
        check("wait_idle", 32'(SRAM_busy), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] sel);
        int lat;
        int bc;
        wait_idle();
        rd_q.push_back(exp_read(addr[8:0], sel));
        read = 1'b1; SRAM_address = addr; byte_select_in = sel;
        @(posedge clk); #1;
        read = 1'b0;
        check("rd_accept_busy", 32'(SRAM_busy), 32'd1);
        lat = 0; bc = 1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (data_en && lat == 0) lat = k;
            if (SRAM_busy) bc++;
            else break;
        end
        check("rd_latency", 32'(lat), 32'(L));
        check("rd_busy_cycles", 32'(bc), 32'(L + 1));
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        logic [8:0] idx;
        logic got;
        wait_idle();
        idx = addr[8:0];
        if (32'(idx) < DEPTH) begin
            for (int b = 0; b < 4; b++) if (sel[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
        wr_q.push_back(32'(idx) >= DEPTH);
        cpu_write = 1'b1; cpu_address = addr; cpu_wdata = data; cpu_byte_sel = sel;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (cpu_ack) begin got = 1'b1; break; end
        end
        cpu_write = 1'b0;
        check("wr_ack_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        check("wr_ack_one_cycle", 32'(cpu_ack), 32'd0);
    endtask

    initial begin
        logic got;
        logic saw_low;
        logic prev_busy;
        int   pulses;
        int   last_cyc;
        int   next_idx;

        total = 0; passed = 0; prev_den = 1'b0;
        read = 1'b0; SRAM_address = '0; byte_select_in = '0;
        cpu_write = 1'b0; cpu_address = '0; cpu_wdata = '0; cpu_byte_sel = '0;

        // Reset held with read asserted: nothing may be accepted.
        nrst = 1'b0;
        read = 1'b1; SRAM_address = 32'h0000_01FF; byte_select_in = 4'hF;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("rst_data", data_from_SRAM, 32'd0);
            check("rst_ctrl", 32'({byte_select_out, data_en, SRAM_busy, cpu_ack, addr_err}), 32'd0);
        end
        rd_q.push_back(exp_read(9'h1FF, 4'hF));
        nrst = 1'b1;
        @(posedge clk); #1;
        check("first_accept_after_release", 32'(SRAM_busy), 32'd1);
        read = 1'b0;
        wait_idle();

        // Write then read, with high address bits ignored on the read.
        do_write(32'h0000_0002, 32'h6AAA_5556, 4'hF);
        do_read(32'hFFFF_FE02, 4'hF);

        // Byte masking.
        do_write(32'h0000_0001, 32'hFFFF_FFFF, 4'hF);
        do_read(32'h0000_0001, 4'b0101);
        do_write(32'h0000_0001, 32'h1234_5678, 4'b1000);
        do_read(32'h0000_0001, 4'hF);
        do_read(32'h0000_0002, 4'h0);

        // Simultaneous read and write: read first, write after busy drops.
        do_write(32'h0000_0000, 32'h1111_1111, 4'hF);
        wait_idle();
        rd_q.push_back(exp_read(9'd0, 4'hF));
        model[0] = 32'hA5A5_A5A5;
        wr_q.push_back(1'b0);
        read = 1'b1; SRAM_address = '0; byte_select_in = 4'hF;
        cpu_write = 1'b1; cpu_address = '0; cpu_wdata = 32'hA5A5_A5A5; cpu_byte_sel = 4'hF;
        @(posedge clk); #1;
        read = 1'b0;
        check("sim_read_wins_busy", 32'(SRAM_busy), 32'd1);
        check("sim_no_early_ack", 32'(cpu_ack), 32'd0);
        got = 1'b0; saw_low = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (cpu_ack) begin got = 1'b1; break; end
            if (!SRAM_busy) saw_low = 1'b1;
        end
        cpu_write = 1'b0;
        check("sim_ack_seen", 32'(got), 32'd1);
        check("sim_ack_after_busy_low", 32'(saw_low), 32'd1);
        do_read(32'h0000_0000, 4'hF);

        // Back-to-back reads with read held high across indices 0..3.
        do_write(32'h1234_0003, 32'hDEAD_BEEF, 4'hF);
        wait_idle();
        rd_q.push_back(exp_read(9'd0, 4'hF));
        read = 1'b1; SRAM_address = 32'd0; byte_select_in = 4'hF;
        prev_busy = SRAM_busy; pulses = 0; last_cyc = 0; next_idx = 1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            if (SRAM_busy && !prev_busy) begin
                if (next_idx < 4) begin
                    SRAM_address = 32'(next_idx);
                    rd_q.push_back(exp_read(9'(next_idx), 4'hF));
                    next_idx++;
                end else begin
                    read = 1'b0;
                end
            end
            prev_busy = SRAM_busy;
            if (data_en) begin
                pulses++;
                if (pulses > 1) check("b2b_gap_ge_lat_plus1", 32'(cyc - last_cyc >= int'(L + 1)), 32'd1);
                last_cyc = cyc;
            end
            if (pulses == 4) break;
        end
        read = 1'b0;
        check("b2b_pulse_count", 32'(pulses), 32'd4);

        // Boundary indices.
        do_write(32'h0000_017F, 32'hCAFE_F00D, 4'hF);
        do_read(32'h0000_017F, 4'hF);
        do_read(32'h0000_0180, 4'hF);
        do_write(32'h0000_0180, 32'h5555_5555, 4'hF);

        // Reset during RD_WAIT drops the response.
        wait_idle();
        read = 1'b1; SRAM_address = 32'd2; byte_select_in = 4'hF;
        @(posedge clk); #1;
        read = 1'b0;
        check("mid_rst_accept", 32'(SRAM_busy), 32'd1);
        @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        check("mid_rst_busy_drop", 32'(SRAM_busy), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("mid_rst_no_den", 32'(data_en), 32'd0);
        end
        nrst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("post_rst_no_den", 32'(data_en), 32'd0);
            check("post_rst_idle", 32'(SRAM_busy), 32'd0);
        end
        do_read(32'h0000_017F, 4'hF);

        // Drain outstanding expectations.
        for (int k = 0; k < 20; k++) begin
            if (rd_q.size() == 0 && wr_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
